// File: rtl/weight_bram_loader.sv
// rtl/weight_bram_loader.sv - packs a 32-bit weight word stream into 128-bit BRAM lines
module weight_bram_loader #(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 128,
    parameter int DEPTH          = 8192,
    localparam int LANES         = DATA_WIDTH_OUT / DATA_WIDTH_IN,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [AW:0]               num_lines,
    input  logic                      s_valid,
    input  logic [DATA_WIDTH_IN-1:0]  s_data,
    output logic                      s_ready,
    output logic                      wr_rd_en,
    output logic [AW-1:0]             wr_addr,
    output logic [DATA_WIDTH_OUT-1:0] data_out,
    output logic                      busy,
    output logic                      done,
    output logic [AW:0]               lines_written
);

    // Lane counter needs at least one bit even when a line is a single word.
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LCW-1:0] LAST_LANE = LCW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                      state;
    logic [AW-1:0]               base_q;
    logic [AW:0]                 num_q;
    logic [LCW-1:0]              lane_cnt;
    logic [AW:0]                 line_idx;
    logic [DATA_WIDTH_OUT-1:0]   pack;
    logic [DATA_WIDTH_OUT-1:0]   line_next;
    logic                        beat;
    logic                        last_lane;
    logic                        last_line;

    // Ready is a pure function of state so the upstream sees it without extra latency.
    assign s_ready   = (state == LOAD);
    assign beat      = s_valid && s_ready;
    assign last_lane = (lane_cnt == LAST_LANE);
    assign last_line = ((line_idx + 1'b1) == num_q);

    // The committed line count is the same register that indexes the next address.
    assign lines_written = line_idx;

    // Completed line: earlier lanes from the pack register, top lane straight from the stream.
    always_comb begin
        line_next = pack;
        line_next[(LANES-1)*DATA_WIDTH_IN +: DATA_WIDTH_IN] = s_data;
    end

    // Control FSM with registered write strobe, address, data, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            lane_cnt <= '0;
            line_idx <= '0;
            pack     <= '0;
            wr_rd_en <= 1'b0;
            wr_addr  <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            wr_rd_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_lines != '0) begin
                            base_q   <= base_addr;
                            num_q    <= num_lines;
                            line_idx <= '0;
                            lane_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            // Empty load completes immediately without touching memory.
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (last_lane) begin
                            wr_rd_en <= 1'b1;
                            data_out <= line_next;
                            // DEPTH is a power of two, so the plain add wraps correctly.
                            wr_addr  <= base_q + line_idx[AW-1:0];
                            lane_cnt <= '0;
                            line_idx <= line_idx + 1'b1;
                            if (last_line) begin
                                state <= FLUSH;
                            end
                        end else begin
                            for (int i = 0; i < LANES - 1; i++) begin
                                if (lane_cnt == LCW'(i)) begin
                                    pack[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] <= s_data;
                                end
                            end
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Final write is on the bus this cycle; signal completion next.
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_bram_loader.sv
// tb/tb_weight_bram_loader.sv - randomized self-checking bench for weight_bram_loader
module tb_weight_bram_loader;

    localparam int DEPTH = 8192;
    localparam int AW    = 13;
    localparam int LANES = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [AW:0]    num_lines = '0;
    logic           s_valid = 1'b0;
    logic [31:0]    s_data = '0;
    logic           s_ready;
    logic           wr_rd_en;
    logic [AW-1:0]  wr_addr;
    logic [127:0]   data_out;
    logic           busy;
    logic           done;
    logic [AW:0]    lines_written;

    weight_bram_loader #(
        .DATA_WIDTH_IN (32),
        .DATA_WIDTH_OUT(128),
        .DEPTH         (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .wr_rd_en     (wr_rd_en),
        .wr_addr      (wr_addr),
        .data_out     (data_out),
        .busy         (busy),
        .done         (done),
        .lines_written(lines_written)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level reference: collected words, lines committed, load/flush phase.
    bit           m_loading  = 1'b0;
    bit           m_flushing = 1'b0;
    int           m_base = 0;
    int           m_num  = 0;
    int           m_lw   = 0;
    logic [31:0]  m_words[$];
    logic [127:0] e_data = '0;
    int           e_addr = 0;
    bit           e_wr   = 1'b0;
    bit           e_done = 1'b0;

    int           wcyc[$];
    int           waddr[$];
    logic [127:0] wdata[$];
    int           done_cyc = -1;

    // Advance the reference on each edge, then compare every DUT output just after it.
    always @(posedge clk) begin
        cyc++;
        e_wr   = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_loading  = 1'b0;
            m_flushing = 1'b0;
            m_words    = {};
            e_data     = '0;
            e_addr     = 0;
            m_lw       = 0;
        end else if (m_flushing) begin
            m_flushing = 1'b0;
            e_done     = 1'b1;
        end else if (m_loading) begin
            if (s_valid) begin
                m_words.push_back(s_data);
                if (m_words.size() == LANES) begin
                    e_data = '0;
                    for (int i = 0; i < LANES; i++) e_data[i*32 +: 32] = m_words[i];
                    e_addr = (m_base + m_lw) % DEPTH;
                    m_lw++;
                    e_wr    = 1'b1;
                    m_words = {};
                    if (m_lw == m_num) begin
                        m_loading  = 1'b0;
                        m_flushing = 1'b1;
                    end
                end
            end
        end else if (start) begin
            if (num_lines == 0) begin
                e_done = 1'b1;
            end else begin
                m_base    = int'(base_addr);
                m_num     = int'(num_lines);
                m_lw      = 0;
                m_loading = 1'b1;
            end
        end
        #1;
        chk("s_ready",       128'(s_ready),       128'(m_loading));
        chk("busy",          128'(busy),          128'(m_loading || m_flushing));
        chk("wr_rd_en",      128'(wr_rd_en),      128'(e_wr));
        chk("done",          128'(done),          128'(e_done));
        chk("wr_addr",       128'(wr_addr),       128'(e_addr));
        chk("data_out",      data_out,            e_data);
        chk("lines_written", 128'(lines_written), 128'(m_lw));
        if (wr_rd_en) begin
            wcyc.push_back(cyc);
            waddr.push_back(int'(wr_addr));
            wdata.push_back(data_out);
        end
        if (done) done_cyc = cyc;
    end

    task automatic clear_log();
        wcyc = {};
        waddr = {};
        wdata = {};
        done_cyc = -1;
    endtask

    task automatic do_start(input int b, input int n);
        base_addr = AW'(b);
        num_lines = (AW+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input int gap);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            total++;
            $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", t);
        end
        @(negedge clk);
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        s_valid = 1'b0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            total++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected 0", t);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        int n;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic contiguous load.
        clear_log();
        do_start(0, 2);
        for (int k = 1; k <= 8; k++) send(32'(k), 0);
        wait_idle();
        chk("basic_nwr",   128'(wcyc.size()), 128'd2);
        chk("basic_addr0", 128'(waddr[0]), 128'd0);
        chk("basic_data0", wdata[0], 128'h00000004_00000003_00000002_00000001);
        chk("basic_addr1", 128'(waddr[1]), 128'd1);
        chk("basic_data1", wdata[1], 128'h00000008_00000007_00000006_00000005);
        chk("basic_gap",   128'(wcyc[1] - wcyc[0]), 128'd4);
        chk("basic_done",  128'(done_cyc - wcyc[1]), 128'd1);
        chk("basic_lw",    128'(lines_written), 128'd2);

        // Valid toggling every cycle.
        clear_log();
        do_start(0, 2);
        for (int k = 1; k <= 8; k++) send(32'(k), 1);
        wait_idle();
        chk("stall_nwr",   128'(wcyc.size()), 128'd2);
        chk("stall_data0", wdata[0], 128'h00000004_00000003_00000002_00000001);
        chk("stall_data1", wdata[1], 128'h00000008_00000007_00000006_00000005);
        chk("stall_gap",   128'(wcyc[1] - wcyc[0]), 128'd8);

        // Address wrap at the top of memory.
        clear_log();
        do_start(8191, 2);
        for (int k = 1; k <= 8; k++) send(32'(k), 0);
        wait_idle();
        chk("wrap_addr0", 128'(waddr[0]), 128'd8191);
        chk("wrap_addr1", 128'(waddr[1]), 128'd0);

        // Zero-length load.
        clear_log();
        c0 = cyc;
        do_start(100, 0);
        wait_idle();
        chk("zero_nwr",  128'(wcyc.size()), 128'd0);
        chk("zero_done", 128'(done_cyc), 128'(c0 + 1));

        // Start during LOAD is ignored.
        clear_log();
        do_start(10, 2);
        send(32'h11, 0);
        send(32'h22, 0);
        s_valid = 1'b0;
        do_start(500, 1);
        for (int k = 3; k <= 8; k++) send(32'(k), 0);
        wait_idle();
        chk("ign_addr0", 128'(waddr[0]), 128'd10);
        chk("ign_addr1", 128'(waddr[1]), 128'd11);
        chk("ign_data0", wdata[0], 128'h00000004_00000003_00000022_00000011);

        // Reset after six beats, then a fresh load.
        clear_log();
        do_start(0, 2);
        for (int k = 1; k <= 6; k++) send(32'(k), 0);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_nwr", 128'(wcyc.size()), 128'd1);
        clear_log();
        do_start(5, 1);
        for (int k = 10; k <= 13; k++) send(32'(k), 0);
        wait_idle();
        chk("rst_addr", 128'(waddr[0]), 128'd5);
        chk("rst_data", wdata[0], 128'h0000000D_0000000C_0000000B_0000000A);

        // Valid held high past the final beat.
        clear_log();
        do_start(20, 2);
        for (int k = 1; k <= 8; k++) send(32'(k), 0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (6) @(negedge clk);
        s_valid = 1'b0;
        chk("bp_nwr", 128'(wcyc.size()), 128'd2);
        chk("bp_lw",  128'(lines_written), 128'd2);

        // Random loads with random gaps and stray start pulses.
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(1, 4));
            do_start(int'($urandom_range(0, DEPTH - 1)), n);
            for (int k = 0; k < n * LANES; k++) begin
                send($urandom, int'($urandom_range(0, 2)));
                if (k < n * LANES - 1 && $urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    do_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)));
                end
            end
            wait_idle();
        end

        // Whole-memory load.
        clear_log();
        do_start(0, DEPTH);
        for (int k = 0; k < DEPTH * LANES; k++) send(32'(k), 0);
        wait_idle();
        chk("full_nwr",   128'(wcyc.size()), 128'(DEPTH));
        chk("full_lw",    128'(lines_written), 128'(DEPTH));
        chk("full_last",  128'(waddr[DEPTH-1]), 128'(DEPTH - 1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
